keypad_press_generator: RTL and testbench

- Synthesizable emulator for the 3x3 key matrix: the responder side of the keypad scan protocol.
- It watches the scanner's column drive and returns row lines as if physical buttons were pressed, with scripted hold times and contact bounce.
- It is used for demo/attract-mode autoplay and as a stimulus source for the keypad scanner and hit-recording path.
- Press commands arrive over a valid/ready interface and are buffered in a small FIFO.

---
 rtl/keypad_press_generator.sv | 235 +++++++++++++++++++++++
 tb/tb_keypad_press_generator.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_press_generator.sv
// Keypad responder: plays queued press commands back onto the 3x3 matrix as row returns,
// with scripted hold time and contact bounce on make and break.
module keypad_press_generator #(
  parameter int BOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES    = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_key,
  input  logic [15:0] cmd_hold,
  input  logic        flush,
  input  logic [2:0]  column,
  output logic [2:0]  row,
  output logic        key_active,
  output logic [3:0]  pressed_key,
  output logic        busy,
  output logic        err_bad_key
);

  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PH_MAX = (BOUNCE_CYCLES > GAP_CYCLES) ? BOUNCE_CYCLES : GAP_CYCLES;
  localparam int PH_W   = (PH_MAX > 2) ? $clog2(PH_MAX) : 1;

  localparam logic [PH_W-1:0] BOUNCE_LAST = PH_W'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
  localparam logic [PH_W-1:0] GAP_LAST    = PH_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [AW:0]     FIFO_FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [3:0]      NO_KEY = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_BOUNCE_IN  = 3'd1,
    S_HOLD       = 3'd2,
    S_BOUNCE_OUT = 3'd3,
    S_GAP        = 3'd4
  } state_t;

  function automatic logic [2:0] row_onehot(input logic [3:0] k);
    case (k)
      4'd0, 4'd1, 4'd2: row_onehot = 3'b001;
      4'd3, 4'd4, 4'd5: row_onehot = 3'b010;
      4'd6, 4'd7, 4'd8: row_onehot = 3'b100;
      default:          row_onehot = 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] col_onehot(input logic [3:0] k);
    case (k)
      4'd0, 4'd3, 4'd6: col_onehot = 3'b001;
      4'd1, 4'd4, 4'd7: col_onehot = 3'b010;
      4'd2, 4'd5, 4'd8: col_onehot = 3'b100;
      default:          col_onehot = 3'b000;
    endcase
  endfunction

  // Command FIFO: entry = {key, hold}
  logic [19:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          fifo_full;
  logic          fifo_empty;
  logic          key_ok;
  logic          accept;
  logic          push;
  logic          pop;
  logic [19:0]   head_entry;
  logic [3:0]    head_key;
  logic [15:0]   head_hold;

  state_t          state_reg;
  state_t          state_next;
  logic [PH_W-1:0] ph_cnt_reg;
  logic [PH_W-1:0] ph_cnt_next;
  logic [15:0]     hold_cnt_reg;
  logic [15:0]     hold_cnt_next;
  logic            contact;

  logic [2:0] row_mask_reg;
  logic [2:0] col_mask_reg;
  logic [3:0] pressed_key_reg;
  logic       key_active_reg;
  logic       err_bad_key_reg;
  logic       col_hit;

  assign fifo_full  = (count_reg == FIFO_FULL_COUNT);
  assign fifo_empty = (count_reg == '0);
  assign cmd_ready  = reset & ~fifo_full & ~flush;
  assign key_ok     = (cmd_key <= 4'd8);
  assign accept     = cmd_valid & cmd_ready;
  assign push       = accept & key_ok;

  assign head_entry = fifo_mem[rd_ptr_reg];
  assign head_key   = head_entry[19:16];
  assign head_hold  = head_entry[15:0];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {cmd_key, cmd_hold};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      state_reg    <= S_IDLE;
      ph_cnt_reg   <= '0;
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      ph_cnt_reg   <= ph_cnt_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  // Hold counter stores cycles remaining minus one, so 16'hFFFF never needs a 17th bit.
  always_comb begin
    state_next    = state_reg;
    ph_cnt_next   = ph_cnt_reg;
    hold_cnt_next = hold_cnt_reg;
    pop           = 1'b0;
    contact       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop           = 1'b1;
          ph_cnt_next   = '0;
          hold_cnt_next = (head_hold == 16'd0) ? 16'd0 : head_hold - 16'd1;
          state_next    = (BOUNCE_CYCLES > 0) ? S_BOUNCE_IN : S_HOLD;
        end
      end
      S_BOUNCE_IN: begin
        contact = ~ph_cnt_reg[0];
        if (ph_cnt_reg == BOUNCE_LAST) begin
          ph_cnt_next = '0;
          state_next  = S_HOLD;
        end else begin
          ph_cnt_next = ph_cnt_reg + 1'b1;
        end
      end
      S_HOLD: begin
        contact = 1'b1;
        if (hold_cnt_reg == 16'd0) begin
          ph_cnt_next = '0;
          if (BOUNCE_CYCLES > 0) begin
            state_next = S_BOUNCE_OUT;
          end else if (GAP_CYCLES > 0) begin
            state_next = S_GAP;
          end else begin
            state_next = S_IDLE;
          end
        end else begin
          hold_cnt_next = hold_cnt_reg - 16'd1;
        end
      end
      S_BOUNCE_OUT: begin
        contact = ph_cnt_reg[0];
        if (ph_cnt_reg == BOUNCE_LAST) begin
          ph_cnt_next = '0;
          state_next  = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
        end else begin
          ph_cnt_next = ph_cnt_reg + 1'b1;
        end
      end
      S_GAP: begin
        if (ph_cnt_reg == GAP_LAST) begin
          ph_cnt_next = '0;
          state_next  = S_IDLE;
        end else begin
          ph_cnt_next = ph_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      row_mask_reg    <= 3'b000;
      col_mask_reg    <= 3'b000;
      pressed_key_reg <= NO_KEY;
      key_active_reg  <= 1'b0;
      err_bad_key_reg <= 1'b0;
    end else begin
      if (pop) begin
        row_mask_reg    <= row_onehot(head_key);
        col_mask_reg    <= col_onehot(head_key);
        pressed_key_reg <= head_key;
      end else if (state_next == S_IDLE) begin
        pressed_key_reg <= NO_KEY;
      end
      key_active_reg  <= contact;
      err_bad_key_reg <= accept & ~key_ok;
    end
  end

  // Rows follow the column drive combinationally: the scanner samples in its own drive cycle.
  assign col_hit = |(column & col_mask_reg);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_row
      assign row[gi] = contact & row_mask_reg[gi] & col_hit;
    end
  endgenerate

  assign key_active  = key_active_reg;
  assign pressed_key = pressed_key_reg;
  assign err_bad_key = err_bad_key_reg;
  assign busy        = (state_reg != S_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_keypad_press_generator.sv
// Bench for keypad_press_generator: directed scenarios plus a random soak, compared against
// a press-timeline model (each press expands into a list of per-clock contact states).
module tb_keypad_press_generator;

  localparam int B = 4;
  localparam int G = 2;
  localparam int D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, cmd_valid, flush;
  logic [3:0]  cmd_key;
  logic [15:0] cmd_hold;
  logic [2:0]  column;
  logic        cmd_ready, key_active, busy, err_bad_key;
  logic [2:0]  row;
  logic [3:0]  pressed_key;

  logic        z_reset, z_valid, z_flush;
  logic [3:0]  z_key;
  logic [15:0] z_hold;
  logic [2:0]  z_column;
  logic        z_ready, z_key_active, z_busy, z_err;
  logic [2:0]  z_row;
  logic [3:0]  z_pressed;

  keypad_press_generator #(.BOUNCE_CYCLES(B), .GAP_CYCLES(G), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_key(cmd_key), .cmd_hold(cmd_hold), .flush(flush), .column(column), .row(row),
    .key_active(key_active), .pressed_key(pressed_key), .busy(busy), .err_bad_key(err_bad_key)
  );

  keypad_press_generator #(.BOUNCE_CYCLES(0), .GAP_CYCLES(0), .FIFO_DEPTH(4)) dut_z (
    .clk(clk), .reset(z_reset), .cmd_valid(z_valid), .cmd_ready(z_ready),
    .cmd_key(z_key), .cmd_hold(z_hold), .flush(z_flush), .column(z_column), .row(z_row),
    .key_active(z_key_active), .pressed_key(z_pressed), .busy(z_busy), .err_bad_key(z_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [19:0] m_q[$];
  bit          m_seq[$];
  logic [3:0]  m_key = 4'hF;
  bit          m_ka = 1'b0;
  bit          m_err = 1'b0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit cur_contact();
    return (m_seq.size() > 0) ? m_seq[0] : 1'b0;
  endfunction

  function automatic logic [2:0] exp_row();
    int r, c;
    if (!cur_contact()) return 3'b000;
    r = int'(m_key) / 3;
    c = int'(m_key) % 3;
    return column[c] ? 3'(1 << r) : 3'b000;
  endfunction

  function automatic bit model_busy();
    return (m_seq.size() > 0) || (m_q.size() > 0);
  endfunction

  task automatic build_seq(input logic [15:0] h);
    int n;
    n = (h == 16'd0) ? 1 : int'(h);
    for (int i = 0; i < B; i++) m_seq.push_back((i % 2) == 0);
    for (int i = 0; i < n; i++) m_seq.push_back(1'b1);
    for (int i = 0; i < B; i++) m_seq.push_back((i % 2) == 1);
    for (int i = 0; i < G; i++) m_seq.push_back(1'b0);
  endtask

  task automatic model_edge();
    bit acc;
    logic [19:0] e;
    if (!reset || flush) begin
      m_q.delete();
      m_seq.delete();
      m_key = 4'hF;
      m_ka  = 1'b0;
      m_err = 1'b0;
    end else begin
      acc   = cmd_valid && (m_q.size() < D);
      m_ka  = cur_contact();
      m_err = acc && (cmd_key > 4'd8);
      if (m_seq.size() > 0) begin
        void'(m_seq.pop_front());
        if (m_seq.size() == 0) m_key = 4'hF;
      end else if (m_q.size() > 0) begin
        e = m_q.pop_front();
        m_key = e[19:16];
        build_seq(e[15:0]);
      end
      if (acc && (cmd_key <= 4'd8)) m_q.push_back({cmd_key, cmd_hold});
    end
  endtask

  // Compare every output against the model, then advance one clock.
  task automatic tick();
    #1;
    check("cmd_ready",   16'(cmd_ready),   16'(reset && !flush && (m_q.size() < D)));
    check("row",         16'(row),         16'(exp_row()));
    check("key_active",  16'(key_active),  16'(m_ka));
    check("pressed_key", 16'(pressed_key), 16'(m_key));
    check("busy",        16'(busy),        16'(model_busy()));
    check("err_bad_key", 16'(err_bad_key), 16'(m_err));
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [3:0] k, input logic [15:0] h);
    cmd_valid = 1'b1;
    cmd_key   = k;
    cmd_hold  = h;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 1000 && model_busy(); i++) tick();
    #1 check(tag, 16'(busy), 16'd0);
  endtask

  logic [12:0] pat;
  logic [3:0]  bp_key [6];
  logic [15:0] bp_hold [6];
  logic [2:0]  z_rows [6];
  logic        z_busys [6];
  int          sent, guard;
  bit          acc;

  initial begin
    reset = 1'b0; flush = 1'b0; cmd_valid = 1'b0; cmd_key = 4'd0; cmd_hold = 16'd0; column = 3'b000;
    z_reset = 1'b0; z_flush = 1'b0; z_valid = 1'b0; z_key = 4'd0; z_hold = 16'd0; z_column = 3'b000;
    @(negedge clk);
    @(negedge clk);

    // Reset state, with a command offered that must not be taken
    cmd_valid = 1'b1; cmd_key = 4'd4; cmd_hold = 16'd3;
    tick();
    cmd_valid = 1'b0;
    tick();
    reset = 1'b1;
    column = 3'b111;
    tick();

    // Key 4, hold 3: full contact sequence with column held at 111
    send(4'd4, 16'd3);
    tick();
    pat = 13'b1010111010100;
    for (int i = 0; i < 13; i++) begin
      #1 check("seq_row", 16'(row), pat[12 - i] ? 16'h2 : 16'h0);
      tick();
    end
    #1 check("seq_idle_busy", 16'(busy), 16'd0);

    // Same press, column scanned 001/010/100
    send(4'd4, 16'd3);
    for (int i = 0; i < 20; i++) begin
      column = 3'(1 << (i % 3));
      tick();
    end

    // Back-pressure: six commands offered while the first press sits in HOLD
    column = 3'b111;
    send(4'd1, 16'd40);
    for (int i = 0; i < 5; i++) tick();
    for (int i = 0; i < 6; i++) begin
      bp_key[i]  = 4'($urandom_range(0, 8));
      bp_hold[i] = 16'($urandom_range(1, 4));
    end
    cmd_valid = 1'b1;
    sent = 0;
    guard = 0;
    while (sent < 6 && guard < 400) begin
      cmd_key  = bp_key[sent];
      cmd_hold = bp_hold[sent];
      if (sent == 4 && m_q.size() == D) begin
        #1 check("full_ready", 16'(cmd_ready), 16'd0);
      end
      acc = (m_q.size() < D);
      tick();
      if (acc) sent++;
      guard++;
    end
    cmd_valid = 1'b0;
    check("bp_all_sent", 16'(sent), 16'd6);
    drain("bp_drain_busy");

    // Out-of-range keys are accepted, flagged and dropped
    send(4'd9, 16'd2);
    #1 check("bad9_err", 16'(err_bad_key), 16'd1);
    check("bad9_busy", 16'(busy), 16'd0);
    tick();
    #1 check("bad9_err_clear", 16'(err_bad_key), 16'd0);
    send(4'd15, 16'd2);
    #1 check("bad15_err", 16'(err_bad_key), 16'd1);
    check("bad15_row", 16'(row), 16'd0);
    tick();
    tick();

    // Flush during HOLD of key 5 with two queued
    send(4'd5, 16'd20);
    send(4'd2, 16'd3);
    send(4'd7, 16'd3);
    for (int i = 0; i < 5; i++) tick();
    #1 check("pre_flush_row", 16'(row), 16'h2);
    flush = 1'b1;
    cmd_valid = 1'b1; cmd_key = 4'd3; cmd_hold = 16'd1;
    #1 check("flush_ready", 16'(cmd_ready), 16'd0);
    tick();
    flush = 1'b0;
    cmd_valid = 1'b0;
    #1 check("flush_row", 16'(row), 16'd0);
    check("flush_key", 16'(pressed_key), 16'hF);
    check("flush_busy", 16'(busy), 16'd0);
    check("flush_ready_after", 16'(cmd_ready), 16'd1);
    tick();
    tick();

    // Reset during BOUNCE_OUT, then a fresh command pops on the next cycle
    send(4'd6, 16'd2);
    for (int i = 0; i < 8; i++) tick();
    reset = 1'b0;
    tick();
    #1 check("rst_key", 16'(pressed_key), 16'hF);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_active", 16'(key_active), 16'd0);
    check("rst_row", 16'(row), 16'd0);
    check("rst_ready", 16'(cmd_ready), 16'd0);
    reset = 1'b1;
    send(4'd3, 16'd1);
    #1 check("post_rst_idle_row", 16'(row), 16'd0);
    tick();
    #1 check("post_rst_row", 16'(row), 16'h2);
    check("post_rst_key", 16'(pressed_key), 16'd3);
    drain("post_rst_drain_busy");

    // Random soak, including hold=0, bad keys, flushes and resets
    for (int i = 0; i < 400; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_key   = 4'($urandom_range(0, 10));
      cmd_hold  = 16'($urandom_range(0, 6));
      column    = 3'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 39) == 0);
      reset     = !($urandom_range(0, 149) == 0);
      tick();
    end
    cmd_valid = 1'b0; flush = 1'b0; reset = 1'b1;
    drain("soak_drain_busy");

    // No-bounce, no-gap instance: keys 0 then 8, hold 2, column 111
    z_reset = 1'b1; z_column = 3'b111;
    @(posedge clk); @(negedge clk);
    z_valid = 1'b1; z_key = 4'd0; z_hold = 16'd2;
    @(posedge clk); @(negedge clk);
    #1 check("z_idle_row", 16'(z_row), 16'd0);
    z_key = 4'd8;
    @(posedge clk); @(negedge clk);
    z_valid = 1'b0;
    z_rows[0] = 3'b001; z_rows[1] = 3'b001; z_rows[2] = 3'b000;
    z_rows[3] = 3'b100; z_rows[4] = 3'b100; z_rows[5] = 3'b000;
    z_busys[0] = 1'b1; z_busys[1] = 1'b1; z_busys[2] = 1'b1;
    z_busys[3] = 1'b1; z_busys[4] = 1'b1; z_busys[5] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1 check("z_row", 16'(z_row), 16'(z_rows[i]));
      check("z_busy", 16'(z_busy), 16'(z_busys[i]));
      @(posedge clk); @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
